// File: rtl/store_buffer_if.sv
// Pipeline-side bundle for the store buffer: store push and load lookup.
// master = MEM stage, slave = store_buffer.
interface store_buffer_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  st_valid;
  logic                  st_ready;
  logic [ADDR_WIDTH-1:0] st_addr;
  logic [31:0]           st_data;
  logic [1:0]            st_size;
  logic                  ld_valid;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [1:0]            ld_size;
  logic                  ld_hit;
  logic [31:0]           ld_fwd_data;
  logic                  ld_stall;

  modport master (
    output st_valid, st_addr, st_data, st_size,
    output ld_valid, ld_addr, ld_size,
    input  st_ready, ld_hit, ld_fwd_data, ld_stall
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_size,
    input  ld_valid, ld_addr, ld_size,
    output st_ready, ld_hit, ld_fwd_data, ld_stall
  );
endinterface

// File: rtl/store_buffer.sv
// MEM-stage store buffer: FIFO of stores drained to the data RAM when the
// port is idle; loads overlapping a buffered store forward or stall.
// Ports: clk, rst_n (async low); sb (store_buffer_if.slave: st_*, ld_*);
// sb_empty; ram_address, ram_data_in, ram_write, ram_read.
// Macro STORE_BUFFER_FWD_EN enables forwarding; otherwise overlaps stall.
module store_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  store_buffer_if.slave         sb,
  output logic                  sb_empty,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [31:0]           ram_data_in,
  output logic [1:0]            ram_write,
  output logic [1:0]            ram_read
);
  localparam int PW  = $clog2(DEPTH);
  localparam int AW1 = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
  logic [31:0]           r_data [DEPTH];
  logic [1:0]            r_size [DEPTH];
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [PW:0]           r_count;

  logic          w_push;
  logic          w_pop;
  logic          w_ovl;
  logic [PW-1:0] w_idx;
  logic          w_fwd_ok;
  logic          w_hit;
  logic          w_stall;
  logic [31:0]   w_mask_data;

  function automatic logic [AW1-1:0] f_bytes(input logic [1:0] s);
    unique case (s)
      2'd1:    f_bytes = AW1'(1);
      2'd2:    f_bytes = AW1'(2);
      2'd3:    f_bytes = AW1'(4);
      default: f_bytes = '0;
    endcase
  endfunction

  // Extra top bit keeps ranges near the top address from wrapping.
  function automatic logic f_overlap(
    input logic [ADDR_WIDTH-1:0] ea,
    input logic [1:0]            es,
    input logic [ADDR_WIDTH-1:0] la,
    input logic [1:0]            ls
  );
    logic [AW1-1:0] e_lo;
    logic [AW1-1:0] l_lo;
    e_lo = {1'b0, ea};
    l_lo = {1'b0, la};
    f_overlap = (e_lo < l_lo + f_bytes(ls)) &&
                (l_lo < e_lo + f_bytes(es));
  endfunction

  assign sb.st_ready = (r_count != (PW+1)'(DEPTH));
  assign sb_empty    = (r_count == '0);
  assign w_push      = sb.st_valid && sb.st_ready &&
                       (sb.st_size != 2'd0);

  // Walk oldest to youngest so the last match is the youngest entry.
  always_comb begin
    w_ovl = 1'b0;
    w_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((PW+1)'(k) < r_count) begin
        if (f_overlap(r_addr[r_head + PW'(k)], r_size[r_head + PW'(k)],
                      sb.ld_addr, sb.ld_size)) begin
          w_ovl = 1'b1;
          w_idx = r_head + PW'(k);
        end
      end
    end
  end

  assign w_fwd_ok = (r_addr[w_idx] == sb.ld_addr) &&
                    (r_size[w_idx] >= sb.ld_size);

  always_comb begin
    unique case (sb.ld_size)
      2'd1:    w_mask_data = {24'b0, r_data[w_idx][7:0]};
      2'd2:    w_mask_data = {16'b0, r_data[w_idx][15:0]};
      2'd3:    w_mask_data = r_data[w_idx];
      default: w_mask_data = '0;
    endcase
  end

`ifdef STORE_BUFFER_FWD_EN
  assign w_hit   = sb.ld_valid && w_ovl && w_fwd_ok;
  assign w_stall = sb.ld_valid && w_ovl && !w_fwd_ok;
  assign sb.ld_fwd_data = w_hit ? w_mask_data : 32'b0;
`else
  logic w_unused;
  assign w_unused = w_fwd_ok ^ (|w_mask_data);
  assign w_hit   = 1'b0;
  assign w_stall = sb.ld_valid && w_ovl;
  assign sb.ld_fwd_data = 32'b0;
`endif

  assign sb.ld_hit   = w_hit;
  assign sb.ld_stall = w_stall;

  // Port is free unless a load actually needs the RAM.
  assign w_pop = (r_count != '0) &&
                 (!sb.ld_valid || w_hit || w_stall);

  always_comb begin
    ram_address = '0;
    ram_data_in = '0;
    ram_write   = 2'd0;
    ram_read    = 2'd0;
    if (sb.ld_valid && !w_ovl) begin
      ram_read    = sb.ld_size;
      ram_address = sb.ld_addr;
    end else if (w_pop) begin
      ram_address = r_addr[r_head];
      ram_data_in = r_data[r_head];
      ram_write   = r_size[r_head];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= sb.st_addr;
      r_data[r_tail] <= sb.st_data;
      r_size[r_tail] <= sb.st_size;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Testbench for store_buffer: directed stores/loads, drain scoreboard.
// Build with or without STORE_BUFFER_FWD_EN; expectations follow it.
module tb_store_buffer;
  logic        clk;
  logic        rst_n;
  logic        sb_empty;
  logic [31:0] ram_address;
  logic [31:0] ram_data_in;
  logic [1:0]  ram_write;
  logic [1:0]  ram_read;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
  } drain_t;

  drain_t sbq[$];

  store_buffer_if #(.ADDR_WIDTH(32)) sbi ();

  store_buffer #(.DEPTH(4), .ADDR_WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sb          (sbi.slave),
    .sb_empty    (sb_empty),
    .ram_address (ram_address),
    .ram_data_in (ram_data_in),
    .ram_write   (ram_write),
    .ram_read    (ram_read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual %h required %h", nm, act, exp);
    end
  endtask

  // Monitor: every RAM write must match the oldest expected store.
  always @(negedge clk) begin
    if (rst_n && ram_write != 2'd0) begin
      chk("port_excl", 32'(ram_read), 32'd0);
      if (sbq.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL drain_unexpected actual %h required none",
                 ram_address);
      end else begin
        drain_t e;
        e = sbq.pop_front();
        chk("drain_addr", ram_address, e.addr);
        chk("drain_data", ram_data_in, e.data);
        chk("drain_size", 32'(ram_write), 32'(e.size));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d,
                    input logic [1:0] s, input bit exp_acc);
    drain_t e;
    sbi.st_valid = 1'b1;
    sbi.st_addr  = a;
    sbi.st_data  = d;
    sbi.st_size  = s;
    if (exp_acc) begin
      e.addr = a;
      e.size = s;
      e.data = d;
      sbq.push_back(e);
    end
  endtask

  task automatic st_off();
    sbi.st_valid = 1'b0;
  endtask

  task automatic ld(input logic v, input logic [31:0] a,
                    input logic [1:0] s);
    sbi.ld_valid = v;
    sbi.ld_addr  = a;
    sbi.ld_size  = s;
  endtask

  initial begin
    rst_n = 1'b0;
    sbi.st_valid = 1'b0;
    sbi.st_addr  = '0;
    sbi.st_data  = '0;
    sbi.st_size  = 2'd0;
    ld(1'b0, 32'h0, 2'd0);
    #2;
    chk("rst_st_ready", 32'(sbi.st_ready), 32'd1);
    chk("rst_empty", 32'(sb_empty), 32'd1);
    chk("rst_ld_hit", 32'(sbi.ld_hit), 32'd0);
    chk("rst_ld_stall", 32'(sbi.ld_stall), 32'd0);
    chk("rst_fwd", sbi.ld_fwd_data, 32'd0);
    chk("rst_ram_write", 32'(ram_write), 32'd0);
    chk("rst_ram_read", 32'(ram_read), 32'd0);
    chk("rst_ram_addr", ram_address, 32'd0);
    chk("rst_ram_din", ram_data_in, 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Reset then drain
    st(32'h100, 32'hDEADBEEF, 2'd3, 1'b1);
    cyc();
    st_off();
    #1;
    chk("t1_drain_write", 32'(ram_write), 32'd3);
    cyc();
    chk("t1_empty", 32'(sb_empty), 32'd1);

    // Fill and block
    ld(1'b1, 32'h800, 2'd3);
    for (int i = 0; i < 4; i++) begin
      st(32'h10 + 32'(4 * i), 32'hA0 + 32'(i), 2'd3, 1'b1);
      #1;
      chk("t2_ld_read", 32'(ram_read), 32'd3);
      cyc();
    end
    st(32'h50, 32'hBAD, 2'd3, 1'b0);
    #1;
    chk("t2_full", 32'(sbi.st_ready), 32'd0);
    cyc();
    st_off();
    ld(1'b0, 32'h0, 2'd0);
    #1;
    chk("t2_still_full", 32'(sbi.st_ready), 32'd0);
    cyc();
    cyc();
    cyc();
    cyc();
    chk("t2_drained", 32'(sb_empty), 32'd1);
    chk("t2_q_empty", 32'(sbq.size()), 32'd0);

    // Full forward
    st(32'h200, 32'h11223344, 2'd3, 1'b1);
    cyc();
    st_off();
    ld(1'b1, 32'h200, 2'd2);
    #1;
    chk("t3_ram_read", 32'(ram_read), 32'd0);
`ifdef STORE_BUFFER_FWD_EN
    chk("t3_hit", 32'(sbi.ld_hit), 32'd1);
    chk("t3_fwd", sbi.ld_fwd_data, 32'h00003344);
    chk("t3_stall", 32'(sbi.ld_stall), 32'd0);
`else
    chk("t3_hit", 32'(sbi.ld_hit), 32'd0);
    chk("t3_stall", 32'(sbi.ld_stall), 32'd1);
`endif
    cyc();
    chk("t3_after_read", 32'(ram_read), 32'd2);
    chk("t3_after_stall", 32'(sbi.ld_stall), 32'd0);
    ld(1'b0, 32'h0, 2'd0);
    cyc();

    // Partial overlap
    st(32'h301, 32'h000000AA, 2'd1, 1'b1);
    cyc();
    st_off();
    ld(1'b1, 32'h300, 2'd3);
    #1;
    chk("t4_stall", 32'(sbi.ld_stall), 32'd1);
    chk("t4_hit", 32'(sbi.ld_hit), 32'd0);
    chk("t4_ram_read", 32'(ram_read), 32'd0);
    cyc();
    chk("t4_after_stall", 32'(sbi.ld_stall), 32'd0);
    chk("t4_after_read", 32'(ram_read), 32'd3);
    ld(1'b0, 32'h0, 2'd0);
    cyc();

    // Youngest wins
    ld(1'b1, 32'h800, 2'd3);
    st(32'h400, 32'h1, 2'd3, 1'b1);
    cyc();
    st(32'h400, 32'h2, 2'd3, 1'b1);
    cyc();
    st_off();
    ld(1'b1, 32'h400, 2'd3);
    for (int i = 0; i < 2; i++) begin
      #1;
`ifdef STORE_BUFFER_FWD_EN
      chk("t5_hit", 32'(sbi.ld_hit), 32'd1);
      chk("t5_fwd", sbi.ld_fwd_data, 32'h2);
`else
      chk("t5_stall", 32'(sbi.ld_stall), 32'd1);
      chk("t5_fwd", sbi.ld_fwd_data, 32'h0);
`endif
      cyc();
    end
    chk("t5_stall_done", 32'(sbi.ld_stall), 32'd0);
    chk("t5_read", 32'(ram_read), 32'd3);
    ld(1'b0, 32'h0, 2'd0);
    cyc();

    // Reset mid-drain
    ld(1'b1, 32'h800, 2'd3);
    for (int i = 0; i < 3; i++) begin
      st(32'h600 + 32'(4 * i), 32'hC0 + 32'(i), 2'd3, 1'b1);
      cyc();
    end
    st_off();
    ld(1'b0, 32'h0, 2'd0);
    #1;
    chk("t6_drain_on", 32'(ram_write), 32'd3);
    chk("t6_drain_addr", ram_address, 32'h600);
    #1;
    rst_n = 1'b0;
    sbq.delete();
    #1;
    chk("t6_rst_write", 32'(ram_write), 32'd0);
    chk("t6_rst_empty", 32'(sb_empty), 32'd1);
    chk("t6_rst_ready", 32'(sbi.st_ready), 32'd1);
    chk("t6_rst_addr", ram_address, 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    cyc();
    chk("t6_empty", 32'(sb_empty), 32'd1);
    chk("end_q_empty", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
# store_buffer

Memory-stage store buffer between the MEM pipeline stage and the byte-addressed data RAM. Accepts stores from the pipeline into a small FIFO and retires them to the RAM one per cycle when the RAM port is not used by a load. Loads read the RAM directly. A load that overlaps a buffered store is either forwarded from the buffer or stalled until the conflicting store has drained. Size encodings match the RAM: 0 none, 1 byte, 2 halfword, 3 word.

## Interface
- DEPTH, 4: number of store entries; power of two, 2..16.
- ADDR_WIDTH, 32: byte-address width; matches the RAM.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- st_valid  in  1  store request this cycle.
- st_ready  out  1  buffer can accept a store; equals !full.
- st_addr  in  ADDR_WIDTH  store byte address.
- st_data  in  32  store data, low bytes used per size.
- st_size  in  2  1=SB, 2=SH, 3=SW; 0 is ignored (no push).
- ld_valid  in  1  load request this cycle.
- ld_addr  in  ADDR_WIDTH  load byte address.
- ld_size  in  2  1=LB, 2=LH, 3=LW.
- ld_hit  out  1  load is satisfied from the buffer; data on ld_fwd_data.
- ld_fwd_data  out  32  forwarded data, zero-padded above ld_size bytes.
- ld_stall  out  1  load conflicts with a buffered store and must be retried.
- sb_empty  out  1  no entries are buffered; used for fences.
- ram_address  out  ADDR_WIDTH  RAM address.
- ram_data_in  out  32  RAM write data.
- ram_write  out  2  RAM store size (0 = no write).
- ram_read  out  2  RAM load size (0 = no read).

## Operation
- Storage is a FIFO of DEPTH entries {addr, data, size}, with head/tail pointers and a count of width clog2(DEPTH)+1.
- **Push:** on st_valid && st_ready && st_size!=0, st_addr/st_data/st_size are written at the tail and the tail advances. Pointers wrap modulo DEPTH.
- **Overlap:** an entry covers the bytes [addr, addr+n), where n = 1, 2 or 4 for size 1, 2 or 3. The load covers the same range computed from ld_addr/ld_size.
  - Ranges are computed in ADDR_WIDTH+1 bits, so there is no wrap past the top address.
  - Only valid entries are checked.
- **Forwarding:** the deciding entry is the youngest overlapping entry.
  - It forwards when its addr == ld_addr and its size >= ld_size. Then ld_hit=1, ld_fwd_data = its data masked to the ld_size bytes, and ram_read=0.
  - In every other overlap case, ld_stall=1, ld_hit=0 and ram_read=0.
  - With no overlap, ram_read=ld_size and ram_address=ld_addr.
- **Drain:** when count>0 and the port is free, the RAM port carries the head entry and the head pops at the edge. The port is free when !ld_valid, or when ld_valid with ld_hit or ld_stall.
  - ram_address = head addr, ram_data_in = head data, ram_write = head size.
  - At most one drain per cycle.
- **Port priority:** a load needing the RAM always wins over a drain. ram_write and ram_read are never both nonzero.
- **Simultaneous push and pop:** the count is unchanged.
- **Full:** st_ready=0 even if a pop occurs in the same cycle; there is no bypass. A store presented while full is not accepted; the pipeline must hold it.
- **Same-cycle store and load:** the load sees only entries present before the edge. The same-cycle store is not forwarded. The pipeline issues at most one memory op per cycle.
- **Reset:** asynchronous; clears the count and pointers. Entry contents are don't-care. A store being drained when reset asserts is lost.

## Timing
- Reset values:
  - st_ready=1, sb_empty=1.
  - ld_hit=0, ld_stall=0, ld_fwd_data=0.
  - ram_write=0, ram_read=0, ram_address=0, ram_data_in=0.
- ld_hit, ld_stall, ld_fwd_data and all ram_* outputs are combinational from the current inputs and registered state.
- Push latency: a store accepted at edge N is forwardable from cycle N+1 and can drain at the earliest at edge N+1.
- st_ready and sb_empty are registered-state functions and do not depend on same-cycle inputs.
- Drain throughput is one store per cycle with no loads present.

## Configuration
- STORE_BUFFER_FWD_EN:
  - Defined: forwarding as described above.
  - Undefined: ld_hit and ld_fwd_data are tied to 0, and every overlap asserts ld_stall.

## Test plan
- **Reset, then drain.** SW 0x100=0xDEADBEEF, then idle.
  - Next cycle: ram_write=3, ram_address=0x100, ram_data_in=0xDEADBEEF.
  - Following cycle: sb_empty=1.
- **Fill and block.** Push 4 stores while ld_valid=1 with a non-overlapping address, so nothing drains.
  - st_ready=0 after the 4th push; a 5th store is not accepted.
  - Drop ld_valid: the stores drain in order over 4 cycles.
- **Full forward.** SW 0x200=0x11223344, then LH 0x200 with STORE_BUFFER_FWD_EN.
  - ld_hit=1, ld_fwd_data=0x00003344, ram_read=0.
- **Partial overlap.** SB 0x301=0xAA, then LW 0x300.
  - ld_stall=1 for one cycle while the SB drains.
  - Next cycle: ld_stall=0 and ram_read=3.
- **Youngest wins.** SW 0x400=0x1, then SW 0x400=0x2, then LW 0x400.
  - ld_fwd_data=0x2.
  - Without the macro: ld_stall=1 until both entries drain.
- **Reset mid-drain.** rst_n low while count=3.
  - count=0, sb_empty=1, ram_write=0 immediately, with no clock edge.
